// File: rtl/riscv_pkg.sv
// Shared core definitions: word width, canonical NOP, reset vector
// and the fetch state encoding.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FULL,
    DROP
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_if.sv
// Fetch front-end bundle: redirect input, imem req/ack port
// and the valid/ready handoff to decode.
interface pc_fetch_if;
  import riscv_pkg::*;

  logic            redirect_i;
  logic [XLEN-1:0] redirect_pc_i;

  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_ack_i;
  logic [XLEN-1:0] imem_rdata_i;

  logic            id_valid_o;
  logic            id_ready_i;
  logic [XLEN-1:0] id_instr_o;
  logic [XLEN-1:0] id_pc_o;

  modport master (
    input  redirect_i,
    input  redirect_pc_i,
    output imem_req_o,
    output imem_addr_o,
    input  imem_ack_i,
    input  imem_rdata_i,
    output id_valid_o,
    input  id_ready_i,
    output id_instr_o,
    output id_pc_o
  );

  modport slave (
    output redirect_i,
    output redirect_pc_i,
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ack_i,
    output imem_rdata_i,
    input  id_valid_o,
    output id_ready_i,
    input  id_instr_o,
    input  id_pc_o
  );

endinterface

// File: rtl/pc_fetch.sv
// Instruction fetch: PC register, imem req/ack sequencing and a
// one-entry output register toward decode.
module pc_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] P_RESET_PC = RESET_PC
) (
  input  logic       clk,
  input  logic       rst,
  pc_fetch_if.master bus
);

  fetch_state_t    r_state;
  fetch_state_t    w_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc;
  logic [XLEN-1:0] r_redir;
  logic [XLEN-1:0] w_redir;
  logic            r_valid;
  logic            w_valid;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_opc;
  logic            w_load;
  logic [XLEN-1:0] w_tgt;

  assign w_tgt = bus.redirect_pc_i & ~32'h0000_0003;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state;
    end
  end

  always_comb begin
    w_state = r_state;
    w_pc    = r_pc;
    w_redir = r_redir;
    w_valid = r_valid;
    w_load  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_state = FETCH;
        if (bus.redirect_i) w_pc = w_tgt;
      end
      FETCH: begin
        if (bus.redirect_i) begin
          if (bus.imem_ack_i) begin
            w_pc = w_tgt;
          end else begin
            w_redir = w_tgt;
            w_state = DROP;
          end
        end else if (bus.imem_ack_i) begin
          w_load  = 1'b1;
          w_valid = 1'b1;
          w_pc    = r_pc + 32'd4;
          w_state = FULL;
        end
      end
      FULL: begin
        if (bus.redirect_i) begin
          w_valid = 1'b0;
          w_pc    = w_tgt;
          w_state = FETCH;
        end else if (bus.id_ready_i) begin
          w_valid = 1'b0;
          w_state = FETCH;
        end
      end
      DROP: begin
        if (bus.imem_ack_i) begin
          w_pc    = bus.redirect_i ? w_tgt : r_redir;
          w_state = FETCH;
        end else if (bus.redirect_i) begin
          w_redir = w_tgt;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= P_RESET_PC;
      r_redir <= P_RESET_PC;
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
      r_opc   <= P_RESET_PC;
    end else begin
      r_pc    <= w_pc;
      r_redir <= w_redir;
      r_valid <= w_valid;
      if (w_load) begin
        r_instr <= bus.imem_rdata_i;
        r_opc   <= r_pc;
      end
    end
  end

  // pc_q is frozen while in DROP, so it is still the outstanding address.
  assign bus.imem_req_o  = (r_state == FETCH) || (r_state == DROP);
  assign bus.imem_addr_o = r_pc;
  assign bus.id_valid_o  = r_valid;
  assign bus.id_instr_o  = r_valid ? r_instr : NOP_INSTR;
  assign bus.id_pc_o     = r_opc;

endmodule
